// File: rtl/rt_pkg.sv
// ---------------------------------------------------------------------------------------------
// rt_pkg
//   Shared types and constants for the ray-tracing datapath.
//   - FIP_ONE / FIP_T_MAX : Q16.16 fixed-point 1.0 and the largest representable t.
//   - RT_TRI_ID_W         : default width of triangle indices and triangle counts.
//   - hit_rec_t           : one closest-hit record {hit, t, id}.
//   - chc_state_t         : closest_hit_collector FSM states.
// ---------------------------------------------------------------------------------------------
package rt_pkg;

   localparam logic signed [31:0] FIP_ONE     = 32'sh0001_0000;
   localparam logic signed [31:0] FIP_T_MAX   = 32'sh7FFF_FFFF;
   localparam int unsigned        RT_TRI_ID_W = 16;

   typedef struct packed {
      logic                   hit;
      logic signed [31:0]     t;
      logic [RT_TRI_ID_W-1:0] id;
   } hit_rec_t;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } chc_state_t;

endpackage

// File: rtl/closest_hit_collector.sv
// ---------------------------------------------------------------------------------------------
// closest_hit_collector
//   Reduces the per-triangle intersection result stream of one ray to its closest hit: the
//   minimum t among beats with i_result=1 and the issue-order index of that triangle. The
//   record is offered downstream over a valid/ready handshake.
//
// Ports
//   i_clk        clock, all state on the rising edge
//   i_rst        asynchronous, active-high reset
//   i_start      begin a new ray (accepted only in IDLE)
//   i_num_tri    triangle count for the ray, sampled with i_start; 0 is legal
//   o_busy       high in COLLECT and DONE
//   i_valid      one intersection result present this cycle
//   i_t          Q16.16 signed t of that result
//   i_result     1 = ray hits that triangle
//   o_hit_valid  hit record valid (DONE)
//   i_hit_ready  downstream accepts the record
//   o_hit        1 = at least one triangle hit
//   o_hit_t      closest t, T_MAX when nothing was hit
//   o_hit_id     0-based index of the closest triangle, 0 when nothing was hit
//   o_err        sticky protocol-violation flag, cleared only by reset
// ---------------------------------------------------------------------------------------------
module closest_hit_collector
   import rt_pkg::*;
#(
   parameter int unsigned        TRI_ID_W = RT_TRI_ID_W,
   parameter logic signed [31:0] T_MAX    = FIP_T_MAX
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic [TRI_ID_W-1:0]        i_num_tri,
   output logic                       o_busy,
   input  logic                       i_valid,
   input  logic signed [31:0]         i_t,
   input  logic                       i_result,
   output logic                       o_hit_valid,
   input  logic                       i_hit_ready,
   output logic                       o_hit,
   output logic signed [31:0]         o_hit_t,
   output logic [TRI_ID_W-1:0]        o_hit_id,
   output logic                       o_err
);

   localparam logic [TRI_ID_W-1:0] ID_ONE = TRI_ID_W'(1);

   // Best-so-far record; width follows TRI_ID_W so the block can be built at other sizes.
   typedef struct packed {
      logic                hit;
      logic signed [31:0]  t;
      logic [TRI_ID_W-1:0] id;
   } best_rec_t;

   chc_state_t          state_q;
   logic [TRI_ID_W-1:0] count_q;
   logic [TRI_ID_W-1:0] num_tri_q;
   best_rec_t           best_q;
   logic                hit_valid_q;
   logic                err_q;

   logic beat_closer;
   logic last_beat;
   logic err_event;

   always_comb begin
      // Strict compare: a tie leaves the earlier index in place.
      beat_closer = i_result && (!best_q.hit || (i_t < best_q.t));
      last_beat   = (count_q == (num_tri_q - ID_ONE));
      // Start is only legal in IDLE, beats only in COLLECT.
      err_event   = (i_start && (state_q != IDLE)) || (i_valid && (state_q != COLLECT));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         num_tri_q   <= '0;
         best_q      <= '0;
         hit_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (err_event) begin
            err_q <= 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (i_start) begin
                  num_tri_q   <= i_num_tri;
                  count_q     <= '0;
                  best_q.hit  <= 1'b0;
                  best_q.t    <= T_MAX;
                  best_q.id   <= '0;
                  if (i_num_tri == '0) begin
                     state_q     <= DONE;
                     hit_valid_q <= 1'b1;
                  end else begin
                     state_q <= COLLECT;
                  end
               end
            end

            COLLECT: begin
               if (i_valid) begin
                  if (beat_closer) begin
                     best_q.hit <= 1'b1;
                     best_q.t   <= i_t;
                     best_q.id  <= count_q;
                  end
                  count_q <= count_q + ID_ONE;
                  if (last_beat) begin
                     state_q     <= DONE;
                     hit_valid_q <= 1'b1;
                  end
               end
            end

            DONE: begin
               if (i_hit_ready) begin
                  state_q     <= IDLE;
                  hit_valid_q <= 1'b0;
               end
            end

            default: begin
               state_q     <= IDLE;
               hit_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy      = (state_q != IDLE);
   assign o_hit_valid = hit_valid_q;
   assign o_hit       = best_q.hit;
   assign o_hit_t     = best_q.t;
   assign o_hit_id    = best_q.id;
   assign o_err       = err_q;

endmodule

// File: tb/tb_closest_hit_collector.sv
module tb_closest_hit_collector;

   localparam int MAXB = 16;

   logic               clk;
   logic               i_rst;
   logic               i_start;
   logic [15:0]        i_num_tri;
   logic               o_busy;
   logic               i_valid;
   logic signed [31:0] i_t;
   logic               i_result;
   logic               o_hit_valid;
   logic               i_hit_ready;
   logic               o_hit;
   logic signed [31:0] o_hit_t;
   logic [15:0]        o_hit_id;
   logic               o_err;

   int errors = 0;
   int checks = 0;

   logic        beat_res [MAXB];
   logic [31:0] beat_t   [MAXB];

   typedef struct packed {
      logic [15:0]      n;
      logic [3:0]       res;
      logic [3:0][31:0] t;
      logic             exp_hit;
      logic [31:0]      exp_t;
      logic [15:0]      exp_id;
   } vec_t;

   vec_t vecs [6];

   closest_hit_collector dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_num_tri   (i_num_tri),
      .o_busy      (o_busy),
      .i_valid     (i_valid),
      .i_t         (i_t),
      .i_result    (i_result),
      .o_hit_valid (o_hit_valid),
      .i_hit_ready (i_hit_ready),
      .o_hit       (o_hit),
      .o_hit_t     (o_hit_t),
      .o_hit_id    (o_hit_id),
      .o_err       (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_rec(input string tag, input logic h, input logic [31:0] t,
                          input logic [15:0] id);
      chk({tag, " valid"}, 32'(o_hit_valid), 32'd1);
      chk({tag, " hit"},   32'(o_hit), 32'(h));
      chk({tag, " t"},     o_hit_t, t);
      chk({tag, " id"},    32'(o_hit_id), 32'(id));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t make_vec(input int n, input logic [3:0] res, input logic [31:0] t0,
                                     input logic [31:0] t1, input logic [31:0] t2,
                                     input logic [31:0] t3, input logic eh,
                                     input logic [31:0] et, input int eid);
      vec_t v;
      v.n = 16'(n); v.res = res;
      v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
      v.exp_hit = eh; v.exp_t = et; v.exp_id = 16'(eid);
      return v;
   endfunction

   // Reference: closest t is the minimum over hitting beats; the id is the first hitting beat
   // carrying that minimum.
   task automatic model(input int n, output logic h, output logic [31:0] t,
                        output logic [15:0] id);
      int signed m;
      h = 1'b0; t = 32'h7FFF_FFFF; id = '0; m = 0;
      for (int i = 0; i < n; i++) begin
         if (beat_res[i]) begin
            if (!h) m = $signed(beat_t[i]);
            else if ($signed(beat_t[i]) < m) m = $signed(beat_t[i]);
            h = 1'b1;
         end
      end
      if (h) begin
         t = 32'(m);
         for (int i = n - 1; i >= 0; i--)
            if (beat_res[i] && $signed(beat_t[i]) == m) id = 16'(i);
      end
   endtask

   // Runs one ray from IDLE using beat_res/beat_t, then checks and accepts the record.
   task automatic send_ray(input string tag, input int n, input int gap_max, input int hold,
                           input logic eh, input logic [31:0] et, input logic [15:0] eid);
      i_start = 1'b1; i_num_tri = 16'(n);
      tick();
      i_start = 1'b0; i_num_tri = 16'hFFFF;
      chk({tag, " busy"}, 32'(o_busy), 32'd1);
      if (n > 0) chk({tag, " early valid"}, 32'(o_hit_valid), 32'd0);
      for (int i = 0; i < n; i++) begin
         int gap = $urandom_range(0, gap_max);
         for (int g = 0; g < gap; g++) begin
            i_t = $urandom; i_result = $urandom_range(0, 1);
            tick();
         end
         i_valid = 1'b1; i_result = beat_res[i]; i_t = beat_t[i];
         tick();
         i_valid = 1'b0; i_t = $urandom; i_result = $urandom_range(0, 1);
         if (i < n - 1) chk({tag, " mid valid"}, 32'(o_hit_valid), 32'd0);
      end
      chk_rec(tag, eh, et, eid);
      for (int w = 0; w < hold; w++) begin
         tick();
         chk_rec({tag, " hold"}, eh, et, eid);
      end
      i_hit_ready = 1'b1;
      tick();
      i_hit_ready = 1'b0;
      chk({tag, " drop valid"}, 32'(o_hit_valid), 32'd0);
      chk({tag, " idle"}, 32'(o_busy), 32'd0);
   endtask

   initial begin
      logic        mh;
      logic [31:0] mt;
      logic [15:0] mid;
      int          n;

      i_rst = 1'b1; i_start = 1'b0; i_num_tri = '0; i_valid = 1'b0; i_t = '0;
      i_result = 1'b0; i_hit_ready = 1'b0;
      #2;
      chk("reset busy",  32'(o_busy), 32'd0);
      chk("reset valid", 32'(o_hit_valid), 32'd0);
      chk("reset hit",   32'(o_hit), 32'd0);
      chk("reset t",     o_hit_t, 32'd0);
      chk("reset id",    32'(o_hit_id), 32'd0);
      chk("reset err",   32'(o_err), 32'd0);
      tick();
      i_rst = 1'b0;
      tick();

      vecs[0] = make_vec(3, 4'b0111, 32'h30000, 32'h10000, 32'h20000, 0, 1, 32'h10000, 1);
      vecs[1] = make_vec(2, 4'b0000, 32'h5, 32'h5, 0, 0, 0, 32'h7FFFFFFF, 0);
      vecs[2] = make_vec(3, 4'b0101, 32'h8000, 32'h1000, 32'h8000, 0, 1, 32'h8000, 0);
      vecs[3] = make_vec(0, 4'b0000, 0, 0, 0, 0, 0, 32'h7FFFFFFF, 0);
      vecs[4] = make_vec(4, 4'b1011, 32'h10000, 32'hFFFF0000, 32'h80000000, 32'hFFFF0000,
                         1, 32'hFFFF0000, 1);
      vecs[5] = make_vec(1, 4'b0001, 32'h7FFFFFFF, 0, 0, 0, 1, 32'h7FFFFFFF, 0);

      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 4; i++) begin
            beat_res[i] = vecs[k].res[i];
            beat_t[i]   = vecs[k].t[i];
         end
         send_ray($sformatf("vec%0d", k), int'(vecs[k].n), 0, 0, vecs[k].exp_hit,
                  vecs[k].exp_t, vecs[k].exp_id);
      end

      for (int r = 0; r < 40; r++) begin
         n = $urandom_range(0, 12);
         for (int i = 0; i < n; i++) begin
            beat_res[i] = ($urandom_range(0, 2) != 0);
            beat_t[i]   = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom_range(0, 3) << 15);
         end
         model(n, mh, mt, mid);
         send_ray($sformatf("rnd%0d", r), n, 2, $urandom_range(0, 2), mh, mt, mid);
      end
      chk("clean err", 32'(o_err), 32'd0);

      // Start arriving with a beat in COLLECT: beat kept, start flagged, count not reloaded.
      i_start = 1'b1; i_num_tri = 16'd2;
      tick();
      i_start = 1'b1; i_num_tri = 16'd5; i_valid = 1'b1; i_result = 1'b1; i_t = 32'h50000;
      tick();
      i_start = 1'b0; i_result = 1'b1; i_t = 32'h60000;
      tick();
      i_valid = 1'b0;
      chk_rec("collect start", 1'b1, 32'h50000, 16'd0);
      chk("collect start err", 32'(o_err), 32'd1);
      i_hit_ready = 1'b1;
      tick();
      i_hit_ready = 1'b0;

      i_rst = 1'b1;
      #3;
      i_rst = 1'b0;
      tick();

      // Beat in IDLE is dropped.
      i_valid = 1'b1; i_result = 1'b1; i_t = 32'h0;
      tick();
      i_valid = 1'b0;
      chk("idle beat t", o_hit_t, 32'd0);
      chk("idle beat busy", 32'(o_busy), 32'd0);
      chk("idle beat err", 32'(o_err), 32'd1);

      // Stall in DONE with stray traffic; record must not move.
      beat_res[0] = 1'b1; beat_t[0] = 32'h40000;
      beat_res[1] = 1'b1; beat_t[1] = 32'h30000;
      i_start = 1'b1; i_num_tri = 16'd2;
      tick();
      i_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         i_valid = 1'b1; i_result = beat_res[i]; i_t = beat_t[i];
         tick();
      end
      i_valid = 1'b0;
      for (int w = 0; w < 5; w++) begin
         i_valid = (w == 1); i_result = 1'b1; i_t = 32'h0;
         i_start = (w == 2); i_num_tri = 16'd0;
         tick();
         chk_rec("stall", 1'b1, 32'h30000, 16'd1);
      end
      i_valid = 1'b0;
      i_start = 1'b1; i_hit_ready = 1'b1; i_num_tri = 16'd0;
      tick();
      i_start = 1'b0; i_hit_ready = 1'b0;
      chk("ready+start idle", 32'(o_busy), 32'd0);
      chk("ready+start valid", 32'(o_hit_valid), 32'd0);
      chk("stall err", 32'(o_err), 32'd1);

      // Reset mid-ray discards the partial result at once.
      i_start = 1'b1; i_num_tri = 16'd3;
      tick();
      i_start = 1'b0;
      i_valid = 1'b1; i_result = 1'b1; i_t = 32'h10000;
      tick();
      i_valid = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      chk("async busy",  32'(o_busy), 32'd0);
      chk("async valid", 32'(o_hit_valid), 32'd0);
      chk("async hit",   32'(o_hit), 32'd0);
      chk("async t",     o_hit_t, 32'd0);
      chk("async id",    32'(o_hit_id), 32'd0);
      chk("async err",   32'(o_err), 32'd0);
      tick();
      i_rst = 1'b0;
      beat_res[0] = 1'b1; beat_t[0] = 32'h20000;
      send_ray("after reset", 1, 0, 0, 1'b1, 32'h20000, 16'd0);
      chk("after reset err", 32'(o_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
